// File: rtl/seg_mux_scheduler.sv
// Time-multiplexes the shared seven_segment decoder across two digit positions,
// blanking both anodes around every switch and snapshotting digit values once per frame.
module seg_mux_scheduler #(
  parameter int REFRESH_CYCLES = 24000,
  parameter int BLANK_CYCLES   = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic       disp_en,
  output logic [3:0] num,
  output logic [1:0] anode_n,
  output logic       frame_tick
);

  localparam int MAX_DUR = (REFRESH_CYCLES > BLANK_CYCLES) ? REFRESH_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] B_LAST = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {
    BLANK1 = 2'd0,
    DIG0   = 2'd1,
    BLANK0 = 2'd2,
    DIG1   = 2'd3
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] count;
  logic             armed;
  logic             slot_done;
  logic [3:0]       shadow1;

  function automatic state_t succ(input state_t s);
    case (s)
      BLANK1:  return DIG0;
      DIG0:    return BLANK0;
      BLANK0:  return DIG1;
      default: return BLANK1;
    endcase
  endfunction

  function automatic logic [1:0] anode_for(input state_t s, input logic en);
    if (en && (s == DIG0)) return 2'b10;
    if (en && (s == DIG1)) return 2'b01;
    return 2'b11;
  endfunction

  // The first edge after reset release only arms the sequencer, so the
  // initial blank slot spans BLANK_CYCLES edges counted from release.
  always_comb begin
    slot_done  = 1'b0;
    next_state = state;
    if ((state == DIG0) || (state == DIG1))
      slot_done = (count == R_LAST);
    else
      slot_done = (count == B_LAST);
    if (armed && slot_done)
      next_state = succ(state);
  end

  // Digit 0 is loaded straight into num at the snapshot and num holds it
  // untouched through DIG0, so num itself serves as the digit-0 shadow.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= BLANK1;
      count      <= '0;
      armed      <= 1'b0;
      shadow1    <= 4'd0;
      num        <= 4'd0;
      anode_n    <= 2'b11;
      frame_tick <= 1'b0;
    end else begin
      armed      <= 1'b1;
      frame_tick <= 1'b0;
      if (armed) begin
        if (slot_done) begin
          state <= next_state;
          count <= '0;
          if (state == DIG1) begin
            shadow1    <= digit1;
            num        <= digit0;
            frame_tick <= 1'b1;
          end else if (state == DIG0) begin
            num <= shadow1;
          end
        end else begin
          count <= count + 1'b1;
        end
      end
      anode_n <= anode_for(next_state, disp_en);
    end
  end

endmodule

// File: tb/tb_seg_mux_scheduler.sv
// Bench for seg_mux_scheduler (R=4, B=2): directed reset/snapshot/tearing/enable
// scenarios followed by randomized traffic, all checked against a frame-phase model.
module tb_seg_mux_scheduler;

  localparam int R   = 4;
  localparam int B   = 2;
  localparam int PER = 2 * (R + B);

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] digit0 = 4'd0;
  logic [3:0] digit1 = 4'd0;
  logic       disp_en = 1'b1;
  logic [3:0] num;
  logic [1:0] anode_n;
  logic       frame_tick;

  seg_mux_scheduler #(.REFRESH_CYCLES(R), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .digit0(digit0), .digit1(digit1),
    .disp_en(disp_en), .num(num), .anode_n(anode_n), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // model state: edges since release, and the frame's latched digit values
  int       rel = 0;
  int       cyc = 0;
  int       last_ft = -1;
  int       m_num = 0;
  int       m_sh1 = 0;
  int       m_an = 3;
  int       m_ft = 0;
  int       prev_num = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] d0, input logic [3:0] d1, input logic e);
    int k;
    int p;
    reset = r; digit0 = d0; digit1 = d1; disp_en = e;
    @(posedge clk);
    cyc++;
    if (!r) begin
      rel = 0; m_num = 0; m_sh1 = 0; m_an = 3; m_ft = 0; last_ft = -1;
    end else begin
      k = rel; rel++;
      m_an = 3; m_ft = 0;
      if (k >= B) begin
        p = (k - B) % PER;
        if (p < R) m_an = e ? 2 : 3;
        else if (p >= R + B && p < 2 * R + B) m_an = e ? 1 : 3;
        if (p == R) m_num = m_sh1;
        if (p == 2 * R + B) begin
          m_ft = 1; m_num = int'(d0); m_sh1 = int'(d1);
        end
      end
    end
    #1;
    chk("anode_n", int'(anode_n), m_an);
    chk("num", int'(num), m_num);
    chk("frame_tick", int'(frame_tick), m_ft);
    chk("anode_not_00", int'(anode_n != 2'b00), 1);
    if (int'(num) != prev_num) chk("num_change_blank", int'(anode_n), 3);
    prev_num = int'(num);
    if (frame_tick) begin
      if (last_ft >= 0) chk("tick_period", cyc - last_ft, PER);
      last_ft = cyc;
    end
  endtask

  initial begin
    // reset held for three edges, then release with 3/7 presented
    for (int i = 0; i < 3; i++) step(1'b0, 4'd3, 4'd7, 1'b1);
    // digit0 tears to 9 mid-DIG0 of frame 2; enable drops 3 edges in frame 3 DIG1
    for (int i = 0; i <= 40; i++)
      step(1'b1, (i >= 15) ? 4'd9 : 4'd3, 4'd7, !(i >= 32 && i <= 34));
    // reset while DIG0 count is 2, then restart
    for (int i = 0; i < 2; i++) step(1'b0, 4'd5, 4'd6, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      logic rr;
      logic ee;
      rr = ($urandom_range(0, 199) != 0);
      ee = ($urandom_range(0, 9) < 8);
      step(rr, 4'($urandom), 4'($urandom), ee);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/seg_mux_scheduler.md
# seg_mux_scheduler

Time-multiplexing controller that shares the single 7-segment decoder between two digit positions of the dual-digit display. It sequences which digit value is presented to the decoder's `num` input and which common-anode transistor is enabled, inserting blanking intervals between switches so ghosting never occurs. Digit values are snapshotted once per frame so a display never shows a half-updated pair. It sits between the digit-producing logic (switch/sum logic) and the `seven_segment` decoder plus anode driver pins.

## Interface
- `REFRESH_CYCLES`, 24000 — clock cycles each digit is lit per frame; 1 ms at 24 MHz. Must be ≥ 1.
- `BLANK_CYCLES`, 240 — clock cycles both anodes are off between digit slots. Must be ≥ 1.
- `clk`  in  1  system clock (HSOSC-derived).
- `reset`  in  1  synchronous, active-low reset; sampled on the rising edge of `clk`.
- `digit0`  in  4  value for digit position 0; any 4-bit value passes through, and the decoder blanks 10–15.
- `digit1`  in  4  value for digit position 1.
- `disp_en`  in  1  display enable; low forces both anodes off, and the FSM keeps running.
- `num`  out  4  digit value routed to the shared `seven_segment` decoder; registered.
- `anode_n`  out  2  active-low anode enables; bit 0 drives digit 0 and bit 1 drives digit 1; registered.
- `frame_tick`  out  1  one-cycle pulse at each frame boundary (snapshot instant).

## Operation
- FSM states, in fixed cyclic order:
  - `BLANK1` lasts `BLANK_CYCLES` cycles, then goes to `DIG0`.
  - `DIG0` lasts `REFRESH_CYCLES` cycles, then goes to `BLANK0`.
  - `BLANK0` lasts `BLANK_CYCLES` cycles, then goes to `DIG1`.
  - `DIG1` lasts `REFRESH_CYCLES` cycles, then goes back to `BLANK1`.
- Duration counter:
  - Width is `$clog2(max(REFRESH_CYCLES, BLANK_CYCLES))`, minimum 1 bit.
  - It is cleared on every state transition.
  - The transition fires in the cycle where `count == duration-1`.
  - The counter never wraps in any other way.
- Snapshot, on the `DIG1`→`BLANK1` transition edge:
  - `shadow0 <= digit0`, `shadow1 <= digit1`, and `num <= digit0` (the input, not the old shadow).
  - `frame_tick` is 1 for exactly this one cycle.
- On the `DIG0`→`BLANK0` edge, `num <= shadow1`.
- `num` is otherwise held constant, so it always changes only while both anodes are off. This gives the decoder a full blank interval to settle.
- Digit inputs changing at any other time have no effect until the next snapshot.
- `anode_n` next-value rule, evaluated each cycle:
  - `2'b10` if next state is `DIG0` and `disp_en` is 1.
  - `2'b01` if next state is `DIG1` and `disp_en` is 1.
  - `2'b11` otherwise.
  - `anode_n` is never `2'b00`.
- `disp_en` low mid-slot turns the lit anode off on the next edge. Raising it again mid-slot relights the current digit on the next edge.
- Reset (asserted at any point, including mid-slot):
  - state = `BLANK1`, count = 0.
  - `shadow0` = `shadow1` = 0, `num` = 4'd0.
  - `anode_n` = 2'b11, `frame_tick` = 0.
  - Reset takes priority over all other logic.
  - Because no snapshot occurs before the first `DIG1`→`BLANK1` transition, the first frame after reset displays "0" on both digits.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Frame period is `2*(REFRESH_CYCLES+BLANK_CYCLES)` cycles. Duty per digit is `REFRESH_CYCLES` / period.
- With `reset` deasserted (sampled high) at edge E0, `anode_n` becomes 2'b10 at edge E0+`BLANK_CYCLES`.
- `disp_en` to `anode_n` latency is 1 cycle.
- Digit input to visible display latency is at most one frame plus `BLANK_CYCLES`, measured from the snapshot edge.
- Within a frame, `anode_n` sequence is: 11 ×B, 10 ×R, 11 ×B, 01 ×R. The `frame_tick` pulse coincides with the first cycle of the 11 ×B segment that precedes 10.

## Test plan
All scenarios use R=4, B=2, so the period is 12.
1. Reset release: hold `reset`=0 for 3 cycles, then 1. Required response:
   - `anode_n`=11 and `num`=0 during reset and for 2 edges after release.
   - Then 10 ×4, 11 ×2, 01 ×4, 11 ×2, repeating.
   - `num`=0 throughout frame 1.
2. Snapshot: `digit0`=3, `digit1`=7 applied before the first `frame_tick`. Required response:
   - On the `frame_tick` edge, `num`=3; it stays 3 through `DIG0`.
   - `num`=7 from the `DIG0`→`BLANK0` edge through `DIG1`.
   - `frame_tick` recurs every 12 cycles.
3. Tearing: change `digit0` from 3 to 9 in the middle of `DIG0`. Required response: `num` stays 3 until the next `frame_tick`, then becomes 9.
4. Enable: drop `disp_en` for 3 cycles mid-`DIG1`. Required response:
   - `anode_n`=11 starting 1 cycle later and for 3 cycles, then 01 again.
   - FSM timing and `frame_tick` cadence are unchanged.
5. Mid-slot reset: assert `reset` at count 2 of `DIG0`. Required response:
   - Next edge: `anode_n`=11, `num`=0, `frame_tick`=0.
   - Sequence restarts exactly as in scenario 1.
6. Invariant check over 1000 random cycles with random `digit0`/`digit1`/`disp_en`:
   - `anode_n` is never 00.
   - `num` changes only in cycles where `anode_n` is 11.
   - `frame_tick` is high exactly once per 12 cycles.
